// File: rtl/ram_pkg.sv
// ram_pkg: shared FSM state type, byte width and index-width helper for the word RAM controller
package ram_pkg;
  localparam int BYTE_W = 8;
  typedef enum logic [1:0] {IDLE, ACCESS, DRAIN, RESP} state_t;
  function automatic int idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/single_port_ram_sync.sv
// single_port_ram_sync: single-port synchronous RAM with a 1-cycle registered read (read-first)
//   clk  clock
//   en   access enable; dout only updates on enabled cycles
//   we   write enable (qualified by en)
//   addr word address, din write data, dout read data
module single_port_ram_sync #(
  parameter int ADDR_WIDTH = 17,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  en,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] dout
);
  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];
  always_ff @(posedge clk)
    if (en) begin
      if (we) mem[addr] <= din;
      dout <= mem[addr];
    end
endmodule

// File: rtl/ram_word_ctrl.sv
// ram_word_ctrl: serialises word read/byte-masked write requests onto a byte-wide synchronous RAM
//   clk_in/rst_in             clock, asynchronous active-high reset
//   req_valid_in/req_ready_out request handshake (ready only when idle, no queuing)
//   req_we_in, req_addr_in, req_wdata_in, req_be_in  request fields (little-endian, byte i at addr+i)
//   rsp_valid_out             one-cycle response pulse
//   rsp_rdata_out             read data, held until the next response; 0 after writes
//   rsp_err_out               misalignment error, valid with rsp_valid_out
//   busy_out                  high whenever not idle
// Optional: define RAM_WORD_CTRL_ALIGN_CHK_EN to reject addresses not aligned to DATA_BYTES.
module ram_word_ctrl import ram_pkg::*; #(
  parameter int ADDR_WIDTH = 17,
  parameter int DATA_BYTES = 4
) (
  input  logic                         clk_in,
  input  logic                         rst_in,
  input  logic                         req_valid_in,
  output logic                         req_ready_out,
  input  logic                         req_we_in,
  input  logic [ADDR_WIDTH-1:0]        req_addr_in,
  input  logic [BYTE_W*DATA_BYTES-1:0] req_wdata_in,
  input  logic [DATA_BYTES-1:0]        req_be_in,
  output logic                         rsp_valid_out,
  output logic [BYTE_W*DATA_BYTES-1:0] rsp_rdata_out,
  output logic                         rsp_err_out,
  output logic                         busy_out
);
  localparam int IW = idx_w(DATA_BYTES);
  localparam int DW = BYTE_W * DATA_BYTES;
  state_t state, state_n;
  logic [IW-1:0] idx;
  logic [ADDR_WIDTH-1:0] addr_q, ram_addr;
  logic we_q, err_q, accept, last, misaligned, ram_en, ram_we;
  logic [DW-1:0] wdata_q, asm_q, rdata_q, word;
  logic [DATA_BYTES-1:0] be_q;
  logic [BYTE_W-1:0] ram_din, ram_dout;
  assign req_ready_out = state == IDLE;
  assign busy_out      = state != IDLE;
  assign rsp_valid_out = state == RESP;
  assign rsp_rdata_out = rdata_q;
  assign rsp_err_out   = rsp_valid_out & err_q;
  assign accept        = req_valid_in & req_ready_out;
  assign last          = idx == IW'(DATA_BYTES - 1);
`ifdef RAM_WORD_CTRL_ALIGN_CHK_EN
  assign misaligned = |(req_addr_in & ADDR_WIDTH'(DATA_BYTES - 1));
`else
  assign misaligned = 1'b0;
`endif
  always_comb begin
    state_n  = state;
    ram_en   = 1'b0;
    ram_we   = 1'b0;
    ram_addr = addr_q + ADDR_WIDTH'(idx);
    ram_din  = wdata_q[idx*BYTE_W +: BYTE_W];
    case (state)
      IDLE:   state_n = accept ? (misaligned ? RESP : ACCESS) : IDLE;
      ACCESS: begin
        ram_en  = 1'b1;
        ram_we  = we_q & be_q[idx];
        state_n = last ? DRAIN : ACCESS;
      end
      DRAIN:  state_n = RESP;
      RESP:   state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
  // the last byte is still on the RAM output during DRAIN; merge it in directly
  always_comb begin
    word = asm_q;
    word[DW-BYTE_W +: BYTE_W] = ram_dout;
  end
  always_ff @(posedge clk_in or posedge rst_in)
    if (rst_in) begin
      state   <= IDLE;
      idx     <= '0;
      addr_q  <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      be_q    <= '0;
      asm_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state <= state_n;
      if (accept) begin
        addr_q  <= req_addr_in;
        we_q    <= req_we_in;
        wdata_q <= req_wdata_in;
        be_q    <= req_be_in;
        idx     <= '0;
        err_q   <= misaligned;
        if (misaligned) rdata_q <= '0;
      end
      if (state == ACCESS) begin
        idx <= idx + 1'b1;
        if (idx != '0) asm_q[(idx-1)*BYTE_W +: BYTE_W] <= ram_dout;
      end
      if (state == DRAIN) rdata_q <= we_q ? '0 : word;
    end
  single_port_ram_sync #(.ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(BYTE_W)) u_ram (
    .clk(clk_in),
    .en(ram_en),
    .we(ram_we),
    .addr(ram_addr),
    .din(ram_din),
    .dout(ram_dout)
  );
endmodule

// File: tb/tb_ram_word_ctrl.sv
// tb_ram_word_ctrl: directed and randomized checks of ram_word_ctrl against a byte-array memory model
module tb_ram_word_ctrl;
  localparam int AW = 17;
  localparam int DB = 4;
`ifdef RAM_WORD_CTRL_ALIGN_CHK_EN
  localparam bit ALIGN = 1'b1;
`else
  localparam bit ALIGN = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b1;
  logic req_valid = 1'b0, req_we = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic [3:0] req_be = '0;
  logic req_ready, rsp_valid, rsp_err, busy;
  logic [31:0] rsp_rdata;
  int total = 0, bad = 0;
  byte unsigned mem [int];

  ram_word_ctrl #(.ADDR_WIDTH(AW), .DATA_BYTES(DB)) dut (
    .clk_in(clk), .rst_in(rst),
    .req_valid_in(req_valid), .req_ready_out(req_ready),
    .req_we_in(req_we), .req_addr_in(req_addr),
    .req_wdata_in(req_wdata), .req_be_in(req_be),
    .rsp_valid_out(rsp_valid), .rsp_rdata_out(rsp_rdata),
    .rsp_err_out(rsp_err), .busy_out(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] m_read(input int a);
    logic [31:0] w = '0;
    for (int i = 0; i < DB; i++) begin
      int x = (a + i) % (1 << AW);
      w[i*8 +: 8] = mem.exists(x) ? mem[x] : 8'h00;
    end
    return w;
  endfunction

  function automatic void m_write(input int a, input logic [31:0] d, input logic [3:0] be);
    for (int i = 0; i < DB; i++)
      if (be[i]) mem[(a + i) % (1 << AW)] = d[i*8 +: 8];
  endfunction

  // one transaction from an idle sample point (#1 after posedge) back to the next idle sample point
  task automatic xfer(input bit we, input int a, input logic [31:0] d, input logic [3:0] be, input string tag);
    bit mis = ALIGN && (a % DB != 0);
    int exp_lat = mis ? 1 : DB + 2;
    logic [31:0] exp_rd = (we || mis) ? 32'h0 : m_read(a);
    int lat = 1;
    bit en_seen = 1'b0;
    req_valid = 1'b1; req_we = we; req_addr = AW'(a); req_wdata = d; req_be = be;
    @(posedge clk); #1;
    req_valid = 1'b0;
    while (!rsp_valid && lat < 20) begin
      en_seen |= dut.ram_en;
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, "/lat"}, lat, exp_lat);
    chk({tag, "/rdata"}, rsp_rdata, exp_rd);
    chk({tag, "/err"}, rsp_err, mis);
    if (mis) chk({tag, "/ram_en"}, en_seen, 0);
    if (we && !mis) m_write(a, d, be);
    @(posedge clk); #1;
    chk({tag, "/pulse_idle"}, {rsp_valid, req_ready, busy}, 3'b010);
  endtask

  initial begin
    int acc, rsps;
    logic [31:0] rd;
    repeat (3) @(posedge clk);
    #1;
    chk("rst/ready", req_ready, 1);
    chk("rst/busy", busy, 0);
    chk("rst/valid", rsp_valid, 0);
    chk("rst/err", rsp_err, 0);
    chk("rst/rdata", rsp_rdata, 0);
    rst = 1'b0;
    @(posedge clk); #1;
    for (int a = 'h100; a <= 'h120; a += 4) xfer(1'b1, a, 32'h0, 4'hF, "clr");
    for (int a = 'h1FFF0; a <= 'h1FFFC; a += 4) xfer(1'b1, a, 32'h0, 4'hF, "clr");
    xfer(1'b1, 'h0, 32'h0, 4'hF, "clr");
    xfer(1'b1, 'h4, 32'h0, 4'hF, "clr");
    xfer(1'b1, 'h200, 32'h0, 4'hF, "clr");

    xfer(1'b1, 'h100, 32'hDEADBEEF, 4'hF, "wr_full");
    xfer(1'b0, 'h100, 32'h0, 4'h0, "rd_full");
    chk("rd_full/literal", rsp_rdata, 32'hDEADBEEF);
    xfer(1'b1, 'h100, 32'h11223344, 4'b0101, "wr_mask");
    xfer(1'b0, 'h100, 32'h0, 4'h0, "rd_mask");
    chk("rd_mask/literal", rsp_rdata, 32'hDE22BE44);
    xfer(1'b1, 'h104, 32'hFFFFFFFF, 4'h0, "wr_be0");
    xfer(1'b0, 'h104, 32'h0, 4'h0, "rd_be0");
    chk("rd_be0/literal", rsp_rdata, 32'h0);

    if (!ALIGN) begin
      xfer(1'b1, 'h1FFFE, 32'hAABBCCDD, 4'hF, "wr_wrap");
      xfer(1'b0, 'h0, 32'h0, 4'h0, "rd_wrap_lo");
      chk("rd_wrap_lo/half", rsp_rdata[15:0], 16'hAABB);
      xfer(1'b0, 'h1FFFC, 32'h0, 4'h0, "rd_wrap_hi");
      chk("rd_wrap_hi/half", rsp_rdata[31:16], 16'hCCDD);
    end else begin
      xfer(1'b0, 'h102, 32'h0, 4'h0, "rd_misaligned");
      xfer(1'b0, 'h100, 32'h0, 4'h0, "rd_aligned");
    end

    rd = m_read('h100);
    acc = 0; rsps = 0;
    req_we = 1'b0; req_addr = AW'('h100); req_valid = 1'b1;
    for (int s = 1; s <= 20; s++) begin
      if (req_valid && req_ready) acc++;
      @(posedge clk); #1;
      chk($sformatf("hold/ready%0d", s), req_ready, (s % 7) == 0);
      chk($sformatf("hold/busy%0d", s), busy, (s % 7) != 0);
      chk($sformatf("hold/valid%0d", s), rsp_valid, (s % 7) == 6);
      if (rsp_valid) begin
        rsps++;
        chk($sformatf("hold/rdata%0d", s), rsp_rdata, rd);
      end
    end
    req_valid = 1'b0;
    @(posedge clk); #1;
    chk("hold/final_idle", {busy, rsp_valid}, 2'b00);
    chk("hold/accepts", acc, 3);
    chk("hold/responses", rsps, 3);

    xfer(1'b0, 'h100, 32'h0, 4'h0, "rd_pre_rst");
    req_valid = 1'b1; req_we = 1'b1; req_addr = AW'('h200); req_wdata = 32'h55667788; req_be = 4'hF;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    chk("midrst/busy_before", busy, 1);
    rst = 1'b1;
    #1;
    chk("midrst/ready", req_ready, 1);
    chk("midrst/busy", busy, 0);
    chk("midrst/valid", rsp_valid, 0);
    chk("midrst/err", rsp_err, 0);
    chk("midrst/rdata", rsp_rdata, 0);
    m_write('h200, 32'h55667788, 4'b0011);
    repeat (2) begin
      @(posedge clk); #1;
      chk("midrst/no_rsp", rsp_valid, 0);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    xfer(1'b0, 'h200, 32'h0, 4'h0, "rd_post_rst");
    chk("rd_post_rst/literal", rsp_rdata, 32'h00007788);

    for (int n = 0; n < 40; n++) begin
      int a = ($urandom_range(0, 1) == 0) ? int'($urandom_range('h100, 'h11C)) : int'($urandom_range('h1FFF8, 'h1FFFF));
      xfer(1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)), $sformatf("rnd%0d", n));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
